instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/branch_target_adder.sv | 12 +
 rtl/instr_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC
// default and instruction/immediate widths.
package instr_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;

  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target = PC+4 of the branch plus the word-scaled offset, wrapping mod 2^32.
module branch_target_adder
  import instr_fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] pc_plus4,
  input  logic [INSTR_W-1:0] offset_ext,
  output logic [INSTR_W-1:0] target
);

  assign target = pc_plus4 + (offset_ext << 2);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, single-entry
// instruction register toward decode. Define FETCH_DELAY_SLOT_EN for delayed branches.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// HOLD  | if_instr valid, waiting for decode to accept it
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [INSTR_W-1:0]  imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                br_taken,
  input  logic [INSTR_W-1:0]  br_offset_ext,
  input  logic [INSTR_W-1:0]  br_pc_plus4,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [INSTR_W-1:0]  if_pc_plus4,
  output logic [IMM_W-1:0]    if_imm
);

  fetch_state_e       state, state_nxt;
  logic [INSTR_W-1:0] pc, pc_nxt, pc_plus4, br_target;
  logic               capture;

  branch_target_adder u_bta (
    .pc_plus4   (br_pc_plus4),
    .offset_ext (br_offset_ext),
    .target     (br_target)
  );

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

`ifdef FETCH_DELAY_SLOT_EN
  logic               pend_vld, pend_vld_nxt;
  logic [INSTR_W-1:0] pend_pc, pend_pc_nxt;

  // A branch never disturbs the fetch in flight; it only redirects the
  // pc update of the next completed fetch. A same-cycle branch is newest.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    capture      = 1'b0;
    pend_vld_nxt = pend_vld;
    pend_pc_nxt  = pend_pc;
    if (br_taken) begin
      pend_vld_nxt = 1'b1;
      pend_pc_nxt  = br_target;
    end
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          capture      = 1'b1;
          state_nxt    = HOLD;
          pend_vld_nxt = 1'b0;
          if (br_taken)      pc_nxt = br_target;
          else if (pend_vld) pc_nxt = pend_pc;
          else               pc_nxt = pc_plus4;
        end
      end
      HOLD: begin
        if (if_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else begin
      pend_vld <= pend_vld_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end
`else
  // Redirect wins over everything; a word returned in the same cycle is dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    if (br_taken) begin
      pc_nxt    = br_target;
      state_nxt = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            capture   = 1'b1;
            state_nxt = HOLD;
            pc_nxt    = pc_plus4;
          end
        end
        HOLD: begin
          if (if_ready) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
    end else begin
      pc <= pc_nxt;
      if (capture) begin
        if_instr    <= imem_rdata;
        if_pc_plus4 <= pc_plus4;
      end
    end
  end

  // Request is masked during reset so an ack in that cycle has nothing to answer.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign if_valid  = (state == HOLD);
  assign if_imm    = if_instr[IMM_W-1:0];

endmodule
